// File: rtl/sweeper_pkg.sv
// Shared types and constants for the vector sweeper.
//   state_t      : sweep FSM states
//   mode_t       : sweep ordering selector
//   DEFAULT_POLY : default MISR feedback polynomial (CCITT-16)
package sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_UP     = 2'd0,
    MODE_GRAY   = 2'd1,
    MODE_DOWN   = 2'd2,
    MODE_UP_ALT = 2'd3
  } mode_t;

  localparam logic [15:0] DEFAULT_POLY = 16'h1021;

endpackage

// File: rtl/misr.sv
// Multiple-input signature register compacting DUT responses.
//   clk, rst_n : clock, async active-low reset (signature -> all ones)
//   seed       : reload all-ones seed
//   en         : fold data into the signature this edge
//   data       : response word, zero-extended to SIG_W
//   sig        : current signature
module misr
  import sweeper_pkg::*;
#(
  parameter int unsigned      SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY),
  parameter int unsigned      N_OUT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed,
  input  logic             en,
  input  logic [N_OUT-1:0] data,
  output logic [SIG_W-1:0] sig
);

  // Galois-style shift with polynomial feedback, then XOR in the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '1;
    end else if (seed) begin
      sig <= '1;
    end else if (en) begin
      sig <= (sig << 1) ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(data);
    end
  end

endmodule

// File: rtl/vector_sweeper.sv
// Exhaustive input-vector sweeper with MISR response compaction.
//   clk, rst_n : clock, async active-low reset
//   start      : level-sampled sweep request (IDLE only)
//   abort      : stop the sweep in progress, no done pulse
//   mode       : 0 binary up, 1 gray, 2 binary down, 3 binary up
//   resp_i     : DUT response, folded at the last cycle of each vector
//   vec_o      : vector applied to the DUT (0 outside a sweep)
//   vec_valid  : vec_o carries a sweep vector
//   vec_idx    : ordinal of the current vector
//   busy       : sweep in progress
//   done       : one-cycle pulse on normal completion
//   signature  : MISR contents
module vector_sweeper
  import sweeper_pkg::*;
#(
  parameter int unsigned      N_IN  = 3,
  parameter int unsigned      N_OUT = 2,
  parameter int unsigned      HOLD  = 10,
  parameter int unsigned      SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [N_OUT-1:0] resp_i,
  output logic [N_IN-1:0]  vec_o,
  output logic             vec_valid,
  output logic [N_IN-1:0]  vec_idx,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature
);

  localparam int unsigned     CNT_W     = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
  localparam logic [N_IN-1:0]  IDX_LAST  = '1;

  state_t           state;
  mode_t            mode_q;
  logic [CNT_W-1:0] hold_cnt;
  logic [N_IN-1:0]  idx_next;
  logic             seed;
  logic             fold;
  logic             hold_end;

  // Ordinal-to-vector mapping for each sweep order.
  function automatic logic [N_IN-1:0] map_vec(input mode_t m, input logic [N_IN-1:0] idx);
    case (m)
      MODE_GRAY: return idx ^ (idx >> 1);
      MODE_DOWN: return ~idx;
      default:   return idx;
    endcase
  endfunction

  assign idx_next = vec_idx + N_IN'(1);
  assign hold_end = (hold_cnt == HOLD_LAST);
  assign seed     = (state == ST_IDLE) && start && !abort;
  // Abort takes priority over the end-of-hold fold.
  assign fold     = (state == ST_APPLY) && !abort && hold_end;

  // Sweep FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_UP;
      hold_cnt  <= '0;
      vec_idx   <= '0;
      vec_o     <= '0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (seed) begin
            state     <= ST_APPLY;
            mode_q    <= mode_t'(mode);
            hold_cnt  <= '0;
            vec_idx   <= '0;
            vec_o     <= map_vec(mode_t'(mode), '0);
            vec_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_APPLY: begin
          if (abort) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            vec_o     <= '0;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (hold_end) begin
            hold_cnt <= '0;
            if (vec_idx == IDX_LAST) begin
              state     <= ST_DONE;
              vec_o     <= '0;
              vec_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              vec_idx <= idx_next;
              vec_o   <= map_vec(mode_q, idx_next);
            end
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .N_OUT (N_OUT)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (seed),
    .en    (fold),
    .data  (resp_i),
    .sig   (signature)
  );

endmodule

// File: tb/tb_vector_sweeper.sv
// Self-checking bench for vector_sweeper: default build (N_IN=3, HOLD=10)
// plus a HOLD=1, N_IN=4 build.
module tb_vector_sweeper;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic        start_a, abort_a;
  logic [1:0]  mode_a, resp_a;
  logic [2:0]  vec_a, idx_a;
  logic        valid_a, busy_a, done_a;
  logic [15:0] sig_a;
  logic        flip_en;

  // Instance B: HOLD=1, N_IN=4
  logic        start_b, abort_b;
  logic [1:0]  mode_b, resp_b;
  logic [3:0]  vec_b, idx_b;
  logic        valid_b, busy_b, done_b;
  logic [15:0] sig_b;

  vector_sweeper dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .mode(mode_a),
    .resp_i(resp_a), .vec_o(vec_a), .vec_valid(valid_a), .vec_idx(idx_a),
    .busy(busy_a), .done(done_a), .signature(sig_a)
  );

  vector_sweeper #(.N_IN(4), .HOLD(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .mode(mode_b),
    .resp_i(resp_b), .vec_o(vec_b), .vec_valid(valid_b), .vec_idx(idx_b),
    .busy(busy_b), .done(done_b), .signature(sig_b)
  );

  // Fixed 2-output response function of the applied vector.
  function automatic logic [1:0] resp_fn(input logic [2:0] v);
    return {v[2] ^ v[0], v[1] & v[0]};
  endfunction

  always_comb begin
    resp_a = resp_fn(vec_a) ^ ((flip_en && valid_a && idx_a == 3'd5) ? 2'b01 : 2'b00);
  end
  assign resp_b = 2'b00;

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [1:0] r);
    return (s << 1) ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, r};
  endfunction

  // Expected signature after nfold vectors of seq, with optional bit flip.
  function automatic logic [15:0] sig_model(input logic [7:0][2:0] seq, input int nfold,
                                            input int flip_at);
    logic [15:0] s;
    logic [1:0]  r;
    s = 16'hFFFF;
    for (int i = 0; i < nfold; i++) begin
      r = resp_fn(seq[i]);
      if (i == flip_at) r = r ^ 2'b01;
      s = misr_step(s, r);
    end
    return s;
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]      mode;
    logic [7:0][2:0] seq;
  } sweep_vec_t;

  sweep_vec_t  tbl [4];
  logic [15:0] sig_ref;

  // One full sweep on instance A, checked every cycle. Entered and left
  // 1 ns after a rising edge with the FSM in IDLE.
  task automatic run_sweep_a(input logic [1:0] m, input logic [7:0][2:0] seq,
                             input logic glitch, input int flip_at);
    mode_a  = m;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (glitch) start_a = (k >= 15 && k < 18);
      check("sweep_cycle", 32'({done_a, busy_a, valid_a, idx_a, vec_a}),
            32'({1'b0, 1'b1, 1'b1, 3'(k / 10), seq[k / 10]}));
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    check("done_pulse", 32'({done_a, busy_a, valid_a, vec_a}), 32'({1'b1, 1'b0, 1'b0, 3'd0}));
    check("sweep_sig", 32'(sig_a), 32'(sig_model(seq, 8, flip_at)));
    @(posedge clk); #1;
    check("done_clear", 32'({done_a, busy_a}), 32'd0);
  endtask

  initial begin
    int saw_done;
    logic [15:0] sig_hold;
    logic [15:0] exp_b;

    tbl[0].mode = 2'd0; tbl[0].seq = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    tbl[1].mode = 2'd1; tbl[1].seq = {3'd4, 3'd5, 3'd7, 3'd6, 3'd2, 3'd3, 3'd1, 3'd0};
    tbl[2].mode = 2'd2; tbl[2].seq = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    tbl[3].mode = 2'd3; tbl[3].seq = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    rst_n = 1'b0; flip_en = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; mode_a = 2'd0;
    start_b = 1'b0; abort_b = 1'b0; mode_b = 2'd0;
    #12;
    check("reset_outs", 32'({done_a, busy_a, valid_a, idx_a, vec_a}), 32'd0);
    check("reset_sig", 32'(sig_a), 32'hFFFF);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // All sweep orders from the table.
    for (int t = 0; t < 4; t++) begin
      run_sweep_a(tbl[t].mode, tbl[t].seq, 1'b0, -1);
      if (t == 0) sig_ref = sig_a;
      repeat (2) @(posedge clk);
      #1;
    end

    // Repeat sweep with start pulsed during APPLY: same vectors and signature.
    run_sweep_a(2'd0, tbl[0].seq, 1'b1, -1);
    check("sig_repeat", 32'(sig_a), 32'(sig_ref));

    // One response bit flipped on vector 5.
    flip_en = 1'b1;
    run_sweep_a(2'd0, tbl[0].seq, 1'b0, 5);
    flip_en = 1'b0;
    check("sig_differs", 32'(sig_a != sig_ref), 32'd1);

    // Abort sampled on the 33rd edge after start.
    mode_a = 2'd0; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    check("pre_abort_idx", 32'(idx_a), 32'd3);
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    check("abort_outs", 32'({done_a, busy_a, valid_a, vec_a}), 32'd0);
    check("abort_sig", 32'(sig_a), 32'(sig_model(tbl[0].seq, 3, -1)));
    sig_hold = sig_a;
    saw_done = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (done_a || busy_a) saw_done++;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    check("abort_sig_frozen", 32'(sig_a), 32'(sig_hold));

    // start and abort together in IDLE: abort wins.
    start_a = 1'b1; abort_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; abort_a = 1'b0;
    check("start_abort_idle", 32'({busy_a, valid_a, vec_a}), 32'd0);

    // Asynchronous reset mid-sweep, then a fresh gray sweep.
    mode_a = 2'd1; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (25) @(posedge clk);
    #2;
    check("pre_reset_busy", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", 32'({done_a, busy_a, valid_a, idx_a, vec_a}), 32'd0);
    check("async_reset_sig", 32'(sig_a), 32'hFFFF);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_sweep_a(tbl[1].mode, tbl[1].seq, 1'b0, -1);

    // HOLD=1, N_IN=4: one vector per cycle.
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("hold1_cycle", 32'({done_b, busy_b, valid_b, idx_b, vec_b}),
            32'({1'b0, 1'b1, 1'b1, 4'(k), 4'(k)}));
      @(posedge clk); #1;
    end
    exp_b = 16'hFFFF;
    for (int k = 0; k < 16; k++) exp_b = misr_step(exp_b, 2'b00);
    check("hold1_done", 32'({done_b, busy_b, valid_b}), 32'b100);
    check("hold1_sig", 32'(sig_b), 32'(exp_b));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_sweeper.md
VECTOR_SWEEPER -- requirements
Module: vector_sweeper

Interface
REQ-001 Parameter N_IN, default 3: width of the applied input vector, range 1..16.
REQ-002 Parameter N_OUT, default 2: width of the DUT response captured per vector, range 1..SIG_W.
REQ-003 Parameter HOLD, default 10: clock cycles each vector is held, range 1..65535.
REQ-004 Parameter SIG_W, default 16: signature register width.
REQ-005 Parameter POLY, default 16'h1021: MISR feedback polynomial, SIG_W bits.
REQ-006 clk  in  1  sole clock; all state changes on the rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  level-sampled request to begin a sweep.
REQ-009 abort  in  1  terminate the sweep in progress.
REQ-010 mode  in  2  sweep order: 0 binary up, 1 gray code, 2 binary down, 3 treated as 0.
REQ-011 resp_i  in  N_OUT  DUT response.
REQ-012 vec_o  out  N_IN  vector applied to the DUT.
REQ-013 vec_valid  out  1  high while vec_o carries a sweep vector.
REQ-014 vec_idx  out  N_IN  ordinal (0..2^N_IN-1) of the current vector.
REQ-015 busy  out  1  sweep in progress.
REQ-016 done  out  1  one-cycle pulse on normal completion.
REQ-017 signature  out  SIG_W  MISR contents.

Function
REQ-018 FSM states SHALL be IDLE, APPLY and DONE.
REQ-019 IDLE with start=1 and abort=0 SHALL go to APPLY and SHALL load vec_idx=0, hold_cnt=0 and signature=all-ones; mode SHALL be latched at this edge.
REQ-020 vec_o SHALL equal f(vec_idx): identity in mode 0; vec_idx^(vec_idx>>1) in mode 1; ~vec_idx in mode 2.
REQ-021 In APPLY, hold_cnt SHALL increment each cycle; each vector SHALL be visible for exactly HOLD cycles.
REQ-022 On the edge where hold_cnt==HOLD-1, resp_i SHALL be folded into the MISR and hold_cnt SHALL clear; vec_idx SHALL increment, or the FSM SHALL go to DONE if vec_idx==2^N_IN-1.
REQ-023 MISR update SHALL be sig_next = (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_extend(resp_i).
REQ-024 DONE SHALL last one cycle with done=1, then the FSM SHALL go to IDLE.
REQ-025 busy and vec_valid SHALL be 1 in APPLY only; vec_o SHALL be 0 outside APPLY.
REQ-026 start while in APPLY or DONE SHALL be ignored.
REQ-027 abort in APPLY SHALL go to IDLE on the next edge without a done pulse and without folding resp_i; signature SHALL hold its last value.
REQ-028 start and abort high together in IDLE: abort SHALL win and the FSM SHALL stay in IDLE.
REQ-029 HOLD=1 SHALL advance the vector every cycle with no idle gap between vectors.
REQ-030 A complete sweep SHALL take 2^N_IN*HOLD cycles from the start edge to DONE entry.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, vec_o=0, vec_idx=0, vec_valid=0, busy=0, done=0 and signature=all-ones, including in the middle of a sweep.
REQ-032 After rst_n rises, the first start edge SHALL begin a fresh sweep.

Structure
REQ-033 Package sweeper_pkg SHALL hold the state enum, the mode enum and the default POLY constant.
REQ-034 The MISR SHALL be a separate sub-module, misr, parametrised on SIG_W, POLY and N_OUT, with load-seed and enable inputs.

Verification
REQ-035 N_IN=3, HOLD=10, mode 0, start pulse -> vec_o 0..7, each held 10 cycles; done pulse 80 cycles after the start edge; busy low afterwards.
REQ-036 Mode 1 -> vec_o 0,1,3,2,6,7,5,4; mode 2 -> vec_o 7,6,...,0.
REQ-037 resp_i = f(vec_o) for a fixed 2-output function, two sweeps -> identical signature; one response bit flipped on vector 5 -> signature differs.
REQ-038 abort on cycle 33 -> IDLE next edge, no done pulse, signature frozen; start during APPLY -> no effect.
REQ-039 rst_n pulled low mid-sweep asynchronously -> all outputs at reset values before the next clk edge; next start -> sweep restarts at vector 0.
REQ-040 HOLD=1, N_IN=4 -> 16 consecutive vectors, one per cycle; done pulse 16 cycles after the start edge.
